// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its load sequencer.
package instr_register_pkg;

  localparam int unsigned REG_DEPTH  = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned OPERAND_W  = 32;
  localparam int unsigned WR_COUNT_W = 6;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic [ADDR_W-1:0]           address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } seq_entry_t;

  typedef enum logic {
    DRAIN,
    HALT
  } seq_state_t;

endpackage

// File: rtl/instr_load_sequencer_fifo.sv
// Power-of-two circular FIFO of sequencer entries with synchronous flush.
module instr_seq_fifo
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  seq_entry_t       i_push_data,
  input  logic             i_pop,
  output seq_entry_t       o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count
);

  seq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (o_count == CNT_W'(DEPTH));
  assign o_empty_c = (o_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full_c && !i_flush;
  assign w_pop     = i_pop && !o_empty_c && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   o_count <= o_count + CNT_W'(1);
        2'b01:   o_count <= o_count - CNT_W'(1);
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_load_sequencer.sv
// Buffers incoming instructions and streams them into the instruction register.
// Define INSTR_SEQ_NOWRAP_EN to halt after the register file is filled once.
module instr_load_sequencer
  import instr_register_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  opcode_t               in_opcode,
  input  operand_t              in_operand_a,
  input  operand_t              in_operand_b,
  input  logic                  flush,
  output logic                  load_en,
  output address_t              write_pointer,
  output opcode_t               opcode,
  output operand_t              operand_a,
  output operand_t              operand_b,
  output logic [WR_COUNT_W-1:0] wr_count,
  output logic                  full_stop
);

  localparam int unsigned CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  seq_entry_t       w_in_entry;
  seq_entry_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_last_load;
  logic             w_hold_ptr;

`ifdef INSTR_SEQ_NOWRAP_EN
  // The load of the last register slot is in flight: no further pops.
  assign w_last_load = load_en && (write_pointer == address_t'(REG_DEPTH - 1));
  assign w_hold_ptr  = (write_pointer == address_t'(REG_DEPTH - 1));
  assign full_stop   = (r_state == HALT);
`else
  assign w_last_load = 1'b0;
  assign w_hold_ptr  = 1'b0;
  assign full_stop   = 1'b0;
`endif

  assign in_ready   = reset_n && (w_count < CNT_W'(FIFO_DEPTH)) && !full_stop;
  assign w_push     = in_valid && in_ready && !w_full && !flush;
  assign w_in_entry = '{opc: in_opcode, op_a: in_operand_a, op_b: in_operand_b};

  instr_seq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_push_data(w_in_entry),
    .i_pop      (w_pop),
    .o_head_c   (w_head),
    .o_full_c   (w_full),
    .o_empty_c  (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= DRAIN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      DRAIN: begin
        w_pop = !w_empty && !flush && !w_last_load;
        if (!flush && w_last_load) w_state_nxt = HALT;
      end
      HALT: begin
        if (flush) w_state_nxt = DRAIN;
      end
      default: w_state_nxt = DRAIN;
    endcase
  end

  // Write port to the instruction register; pointer advances after each load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      wr_count      <= '0;
    end else if (flush) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      wr_count      <= '0;
    end else begin
      load_en <= w_pop;
      if (w_pop) begin
        opcode    <= w_head.opc;
        operand_a <= w_head.op_a;
        operand_b <= w_head.op_b;
      end
      if (load_en) begin
        if (!w_hold_ptr) write_pointer <= write_pointer + address_t'(1);
        if (wr_count < WR_COUNT_W'(REG_DEPTH)) wr_count <= wr_count + WR_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Scoreboard bench for instr_load_sequencer: random pushes, flushes and resets.
module tb_instr_load_sequencer;
  import instr_register_pkg::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     in_valid;
  logic     in_ready;
  opcode_t  in_opcode;
  operand_t in_operand_a;
  operand_t in_operand_b;
  logic     flush;
  logic     load_en;
  address_t write_pointer;
  opcode_t  opcode;
  operand_t operand_a;
  operand_t operand_b;
  logic [5:0] wr_count;
  logic     full_stop;

  always #5 clk = ~clk;

  instr_load_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
    .flush(flush), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .wr_count(wr_count), .full_stop(full_stop)
  );

  typedef struct {
    opcode_t  opc;
    operand_t a;
    operand_t b;
    int       addr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int load_cnt = 0;
  int run = 0;
  int max_run = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the n-th instruction accepted since reset/flush lands at
  // address n mod 32, unless no-wrap mode stops after the 32nd.
`ifdef INSTR_SEQ_NOWRAP_EN
  localparam bit NOWRAP = 1'b1;
`else
  localparam bit NOWRAP = 1'b0;
`endif

  function automatic int exp_ptr(input int n);
    if (NOWRAP) return (n >= 32) ? 31 : n;
    return n % 32;
  endfunction

  task automatic record(input opcode_t o, input operand_t a, input operand_t b);
    if (!NOWRAP || n_acc < 32) sb.push_back('{opc: o, a: a, b: b, addr: n_acc % 32});
    n_acc++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && load_en) begin
      load_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: got load_en=1 at ptr %0d expected no load", write_pointer);
      end else begin
        e = sb.pop_front();
        check("load_opcode", longint'(opcode), longint'(e.opc));
        check("load_operand_a", longint'(operand_a), longint'(e.a));
        check("load_operand_b", longint'(operand_b), longint'(e.b));
        check("load_write_pointer", longint'(write_pointer), longint'(e.addr));
      end
    end else begin
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push(input opcode_t o, input operand_t a, input operand_t b, output bit acc);
    bit r;
    in_valid     = 1'b1;
    in_opcode    = o;
    in_operand_a = a;
    in_operand_b = b;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) begin
        acc = 1'b1;
        record(o, a, b);
      end
    end
  endtask

  task automatic push_rand(output bit acc);
    push(opcode_t'($urandom_range(0, 7)), operand_t'($urandom), operand_t'($urandom), acc);
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    n_acc = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    idle(3);
    check(name, longint'(sb.size()), 0);
  endtask

  task automatic check_state();
    check("wr_count", longint'(wr_count), longint'((n_acc > 32) ? 32 : n_acc));
    check("write_pointer_idle", longint'(write_pointer), longint'(exp_ptr(n_acc)));
    check("full_stop", longint'(full_stop), longint'(NOWRAP && n_acc >= 32));
  endtask

  initial begin : stim
    bit acc;
    int l0;
    int drops;
    reset_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    in_opcode = ZERO;
    in_operand_a = '0;
    in_operand_b = '0;

    #12;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_load_en", longint'(load_en), 0);
    check("rst_write_pointer", longint'(write_pointer), 0);
    check("rst_opcode", longint'(opcode), longint'(ZERO));
    check("rst_wr_count", longint'(wr_count), 0);
    check("rst_full_stop", longint'(full_stop), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Single instruction: load_en one cycle after the cycle following accept.
    push(ADD, 32'sd5, -32'sd3, acc);
    in_valid = 1'b0;
    check("single_accept", longint'(acc), 1);
    check("latency_not_yet", longint'(load_en), 0);
    step();
    check("latency_load", longint'(load_en), 1);
    step();
    check("single_pulse", longint'(load_en), 0);
    wait_drain("drain_single");
    check_state();

    // Ten back-to-back pushes stream straight through.
    do_flush();
    l0 = load_cnt;
    drops = 0;
    max_run = 0;
    for (int i = 0; i < 10; i++) begin
      push_rand(acc);
      if (!acc) drops++;
    end
    idle(3);
    check("burst_ready_drops", longint'(drops), 0);
    check("burst_loads", longint'(load_cnt - l0), 10);
    check("burst_consecutive", longint'(max_run), 10);
    wait_drain("drain_burst");
    check_state();

    // Register file boundary: wrap to 0, or halt with entries held.
    do_flush();
    for (int i = 0; i < (NOWRAP ? 35 : 33); i++) push_rand(acc);
    idle(2);
    wait_drain("drain_boundary");
    check_state();
    if (NOWRAP) begin
      check("halt_in_ready", longint'(in_ready), 0);
      check("halt_entries_held", longint'(n_acc > 32), 1);
      do_flush();
      check("flush_in_ready", longint'(in_ready), 1);
      idle(5);
      check_state();
    end

    // Random traffic with occasional idles.
    for (int round = 0; round < 4; round++) begin
      do_flush();
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) != 0) push_rand(acc);
        else idle($urandom_range(1, 3));
      end
      idle(1);
      wait_drain("drain_random");
      check_state();
    end

    // Flush overriding a simultaneous push.
    do_flush();
    idle(2);
    in_valid = 1'b1;
    in_opcode = MULT;
    in_operand_a = 32'sd7;
    in_operand_b = 32'sd2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    idle(5);
    check_state();

    // Asynchronous reset in the middle of a burst.
    do_flush();
    for (int i = 0; i < 3; i++) push_rand(acc);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    n_acc = 0;
    in_valid = 1'b0;
    check("mid_rst_load_en", longint'(load_en), 0);
    check("mid_rst_write_pointer", longint'(write_pointer), 0);
    check("mid_rst_opcode", longint'(opcode), longint'(ZERO));
    check("mid_rst_operand_a", longint'(operand_a), 0);
    check("mid_rst_wr_count", longint'(wr_count), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);
    check_state();
    push(SUB, -32'sd9, 32'sd4, acc);
    check("post_rst_accept", longint'(acc), 1);
    idle(1);
    wait_drain("drain_post_reset");
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
